// File: rtl/vc_merge_arbiter.sv
// vc_merge_arbiter: merges four virtual-channel class FIFOs into one output
// FIFO. A round-robin grant pops at most one non-empty class FIFO per cycle,
// and the word it returns is pushed to the output FIFO on the following
// cycle. Words forwarded from each class are counted. New pops stall while
// the output FIFO is almost full.
module vc_merge_arbiter #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        empty,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              almost_full,
    output logic [3:0]        pop,
    output logic              push,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        class_out,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3,
    output logic              idle
);

    localparam int unsigned NUM_CLS = 4;
    localparam int unsigned CLS_W   = 2;

    logic [CLS_W-1:0] rr_ptr;
    logic [CLS_W-1:0] sel_d;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_q [NUM_CLS];

    logic             grant;
    logic [CLS_W-1:0] grant_idx;
    logic [CLS_W-1:0] cand;

    // Round-robin scan starting at rr_ptr; first non-empty class wins.
    // Reset and output back-pressure suppress every pop.
    always_comb begin
        pop       = '0;
        grant     = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        if (!reset && !almost_full) begin
            for (int unsigned i = 0; i < NUM_CLS; i++) begin
                cand = rr_ptr + CLS_W'(i);
                if (!grant && !empty[cand]) begin
                    grant     = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant) begin
                pop[grant_idx] = 1'b1;
            end
        end
    end

    // Pointer and in-flight tracking: remember which class was popped so its
    // read data can be steered to the output FIFO on the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            sel_d   <= '0;
            valid_d <= 1'b0;
        end else if (grant) begin
            rr_ptr  <= grant_idx + CLS_W'(1);
            sel_d   <= grant_idx;
            valid_d <= 1'b1;
        end else begin
            valid_d <= 1'b0;
        end
    end

    // An in-flight word is always pushed; reset drops it.
    always_comb begin
        push      = valid_d & ~reset;
        class_out = sel_d;
        idle      = (&empty) & ~valid_d;
    end

    // Steer the read data of the class popped last cycle to the output.
    always_comb begin
        data_out = data_in0;
        case (sel_d)
            2'd0:    data_out = data_in0;
            2'd1:    data_out = data_in1;
            2'd2:    data_out = data_in2;
            default: data_out = data_in3;
        endcase
    end

    // Per-class forwarded-word counters; they wrap rather than saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CLS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (push) begin
            cnt_q[sel_d] <= cnt_q[sel_d] + CNT_W'(1);
        end
    end

    // Expose the counter array on the individual count ports.
    always_comb begin
        cnt0 = cnt_q[0];
        cnt1 = cnt_q[1];
        cnt2 = cnt_q[2];
        cnt3 = cnt_q[3];
    end

endmodule

// File: tb/tb_vc_merge_arbiter.sv
// Testbench for vc_merge_arbiter: directed cycle vectors with hand-computed
// pop patterns; expected pushes go into a queue that an independent monitor
// drains whenever a push is due.
module tb_vc_merge_arbiter;

    localparam int unsigned DATA_W = 6;
    localparam int unsigned CNT_W  = 8;

    typedef struct {
        int         due;
        logic [1:0] cls;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        empty;
    logic [DATA_W-1:0] din [4];
    logic              almost_full;
    logic [3:0]        pop;
    logic              push;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        class_out;
    logic [CNT_W-1:0]  cnt0, cnt1, cnt2, cnt3;
    logic              idle;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q [$];

    vc_merge_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .empty      (empty),
        .data_in0   (din[0]),
        .data_in1   (din[1]),
        .data_in2   (din[2]),
        .data_in3   (din[3]),
        .almost_full(almost_full),
        .pop        (pop),
        .push       (push),
        .data_out   (data_out),
        .class_out  (class_out),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .cnt3       (cnt3),
        .idle       (idle)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every push must match the oldest expectation due this cycle.
    always @(negedge clk) begin
        if (reset) begin
            chk("push_in_reset", int'(push), 0);
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("push", int'(push), 1);
            chk("class_out", int'(class_out), int'(exp_q[0].cls));
            chk("data_out", int'(data_out), int'(din[exp_q[0].cls]));
            void'(exp_q.pop_front());
        end else begin
            chk("no_push", int'(push), 0);
        end
    end

    // Apply one cycle of inputs, check the grant, and record the push it implies.
    task automatic drive(input logic rst, input logic [3:0] emp, input logic af,
                         input logic [3:0] exp_pop, input bit fwd);
        exp_t e;
        reset       = rst;
        empty       = emp;
        almost_full = af;
        for (int k = 0; k < 4; k++) din[k] = DATA_W'(cyc * 5 + k * 13);
        @(negedge clk);
        chk("pop", int'(pop), int'(exp_pop));
        if (fwd && exp_pop != 4'b0000) begin
            e.due = cyc + 1;
            e.cls = 2'd0;
            for (int k = 0; k < 4; k++) if (exp_pop[k]) e.cls = 2'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic rst, input logic [3:0] emp, input logic af,
                         input logic [3:0] exp_pop, input bit fwd);
        drive(rst, emp, af, exp_pop, fwd);
        adv();
    endtask

    task automatic chk_cnts(input int c0, input int c1, input int c2, input int c3);
        chk("cnt0", int'(cnt0), c0);
        chk("cnt1", int'(cnt1), c1);
        chk("cnt2", int'(cnt2), c2);
        chk("cnt3", int'(cnt3), c3);
    endtask

    initial begin
        reset       = 1'b1;
        empty       = 4'b0000;
        almost_full = 1'b0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        adv();

        // Reset with all classes non-empty: no pops, counters cleared.
        cycle(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("idle_in_reset", int'(idle), 0);
        adv();
        chk_cnts(0, 0, 0, 0);
        chk("class_out_reset", int'(class_out), 0);

        // Round-robin with all classes non-empty, then three more grants.
        cycle(1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 4'b1000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 4'b1000, 1'b1);

        // Skip empties: only classes 1 and 3 have data, pointer at 0.
        cycle(1'b0, 4'b0101, 1'b0, 4'b0010, 1'b1);
        cycle(1'b0, 4'b0101, 1'b0, 4'b1000, 1'b1);
        cycle(1'b0, 4'b0101, 1'b0, 4'b0010, 1'b1);

        // Back-pressure: trailing push of class 2, then a stall, then resume.
        cycle(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0, 4'b1000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1);

        // Drain: last word still in flight, then idle.
        drive(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        chk("idle_in_flight", int'(idle), 0);
        adv();
        chk("idle_drained", int'(idle), 1);
        chk_cnts(3, 5, 3, 4);

        // Reset mid-flight: class 2 word is dropped and not counted.
        cycle(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("cnt2_dropped", int'(cnt2), 3);
        adv();
        chk_cnts(0, 0, 0, 0);
        // Scan restarts at class 0 (a held pointer of 3 would pick class 3).
        cycle(1'b0, 4'b0110, 1'b0, 4'b0001, 1'b1);

        // Counter wrap: 256 more words from class 0 only, 257 in total.
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 4'b1110, 1'b0, 4'b0001, 1'b1);
        end
        drive(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        chk("idle_wrap_flight", int'(idle), 0);
        adv();
        chk("idle_wrap_done", int'(idle), 1);
        chk_cnts(1, 0, 0, 0);

        cycle(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
